// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO console responder.
//   - MEM_PUTC / MEM_EXIT / MEM_STATUS : decoded byte addresses
//   - tx_state_e                       : UART TX FSM encoding
//   - ST_*                             : STATUS register bit positions
package mmio_pkg;

  localparam logic [31:0] MEM_PUTC   = 32'h8000_001c;
  localparam logic [31:0] MEM_EXIT   = 32'h8000_002c;
  localparam logic [31:0] MEM_STATUS = 32'h8000_0020;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // STATUS = {16'b0, count[7:0], 5'b0, tx_busy, fifo_empty, fifo_full}
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_COUNT = 8;

endpackage

// File: rtl/mmio_console_fifo.sv
// console_fifo: synchronous character FIFO for the console TX path.
// Ports:
//   clk, resetb      clock, async active-low reset (pointers only)
//   push, din        write strobe/data; ignored when full
//   pop, dout        read strobe; dout shows the head entry (fall-through)
//   full, empty      occupancy flags
//   count            entries held, 0..DEPTH
module console_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty; subtraction wraps.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console / exit responder on the dmem side.
//   PUTC writes queue a byte for 8N1 serial output on tx; EXIT writes latch
//   exit_code and raise sticky exit_req once all queued bytes have drained.
//   STATUS reads return {16'b0, count[7:0], 5'b0, tx_busy, empty, full}.
// Ports:
//   clk, resetb                        clock, async active-low reset
//   dmem_wready/waddr/wdata/wstrb      write request from the core
//   dmem_wvalid                        write accepted (comb; 0 = hold)
//   dmem_rready/raddr                  read request from the core
//   dmem_rdata/rvalid                  registered read response
//   hit                                current request decodes here
//   tx                                 UART out, idle high
//   exit_req, exit_code                sticky exit flag and value
// Build option: define MMIO_CONSOLE_SIM_PRINT_EN to echo characters and the
// exit event to the simulator console.
module mmio_console
  import mmio_pkg::*;
#(
  parameter logic [31:0] PUTC_ADDR   = MEM_PUTC,
  parameter logic [31:0] EXIT_ADDR   = MEM_EXIT,
  parameter logic [31:0] STATUS_ADDR = MEM_STATUS,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          BAUD_DIV    = 16
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        dmem_wready,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_wvalid,
  input  logic        dmem_rready,
  input  logic [31:0] dmem_raddr,
  output logic [31:0] dmem_rdata,
  output logic        dmem_rvalid,
  output logic        hit,
  output logic        tx,
  output logic        exit_req,
  output logic [31:0] exit_code
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  logic          wr_putc, wr_exit, rd_stat, accept, push, exit_acc;
  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          exit_pending_q, exit_pending_d;
  logic          exit_req_q, exit_req_d;
  logic [31:0]   exit_code_q, exit_code_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          baud_end;
  logic          unused_wstrb;

  assign unused_wstrb = ^dmem_wstrb[3:1];

  assign wr_putc     = dmem_wready && (dmem_waddr == PUTC_ADDR);
  assign wr_exit     = dmem_wready && (dmem_waddr == EXIT_ADDR);
  assign rd_stat     = dmem_rready && (dmem_raddr == STATUS_ADDR);
  assign hit         = wr_putc || wr_exit || rd_stat;
  // Only a PUTC into a full FIFO stalls; everything else is taken at once.
  assign dmem_wvalid = !(wr_putc && fifo_full);
  assign accept      = dmem_wready && dmem_wvalid;
  assign push        = accept && wr_putc && dmem_wstrb[0];
  assign exit_acc    = accept && wr_exit;

  console_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (push),
    .pop    (pop),
    .din    (dmem_wdata[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    status                  = '0;
    status[ST_FULL]         = fifo_full;
    status[ST_EMPTY]        = fifo_empty;
    status[ST_BUSY]         = (state_q != IDLE);
    status[ST_COUNT +: 8]   = 8'(fifo_count);
  end

  // TX FSM: baud counter held at 0 in IDLE, restarted on every bit boundary.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    baud_end = (baud_q == BAUD_LAST);
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the current state, so a frame starts on the
    // edge after the pop and each bit lasts exactly BAUD_DIV cycles.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Exit: wait until both the FIFO and the shifter are empty. The code is
  // frozen once exit_req is raised.
  always_comb begin
    exit_pending_d = exit_pending_q || exit_acc;
    exit_code_d    = (exit_acc && !exit_req_q) ? dmem_wdata : exit_code_q;
    exit_req_d     = exit_req_q ||
                     (exit_pending_q && fifo_empty && (state_q == IDLE));
    rvalid_d       = rd_stat;
    rdata_d        = rd_stat ? status : rdata_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q        <= IDLE;
      baud_q         <= '0;
      idx_q          <= '0;
      shift_q        <= '0;
      tx_q           <= 1'b1;
      exit_pending_q <= 1'b0;
      exit_req_q     <= 1'b0;
      exit_code_q    <= '0;
      rdata_q        <= '0;
      rvalid_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      baud_q         <= baud_d;
      idx_q          <= idx_d;
      shift_q        <= shift_d;
      tx_q           <= tx_d;
      exit_pending_q <= exit_pending_d;
      exit_req_q     <= exit_req_d;
      exit_code_q    <= exit_code_d;
      rdata_q        <= rdata_d;
      rvalid_q       <= rvalid_d;
    end
  end

  assign tx          = tx_q;
  assign exit_req    = exit_req_q;
  assign exit_code   = exit_code_q;
  assign dmem_rdata  = rdata_q;
  assign dmem_rvalid = rvalid_q;

`ifdef MMIO_CONSOLE_SIM_PRINT_EN
  always @(posedge clk) begin
    if (resetb && push) $write("%c", dmem_wdata[7:0]);
    if (resetb && exit_req_d && !exit_req_q)
      $display("Program terminate, exit_code=%0d", exit_code_q);
  end
`else
  // Default build: no simulation output.
`endif

endmodule
